vga_vram_arbiter: RTL and testbench

- Shares one single-port synchronous video RAM (VRAM) between two users: display scanout, which has priority, and a game-logic write port.
- Scanout reads one cell of CELL_SIZE×CELL_SIZE pixels per RAM access. Each read is prefetched 3 clocks ahead of use, using the raw column/row counters from VGA_Control.
- Writes use a req/ack handshake and are granted only in cycles that are not scan slots.
- Sits between VGA_Control and the colour/palette stage.

---
 rtl/vga_vram_arbiter.sv | 142 ++++++++++++++
 tb/tb_vga_vram_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_vram_arbiter.sv
// vga_vram_arbiter: shares one single-port synchronous VRAM between display
// scanout (priority) and a game-logic write port.
//
// Scanout fetches one cell per RAM access, three clocks ahead of use, so the
// cell value reaches the palette stage exactly when its first pixel is drawn.
// Writes use a req/ack handshake and fill any cycle that is not a scan slot.
//
// Optional feature: define VGA_ARB_BLANK_WR_EN to restrict writes to
// blanking (Disp_Ena_In=0) for tear-free updates.
//
// Command register states:
//   state     | meaning
//   CMD_NONE  | RAM idle this cycle; address holds, no write
//   CMD_READ  | scanout prefetch address on RAM
//   CMD_WRITE | game-logic write on RAM (acked this cycle)

module vga_vram_arbiter #(
  parameter int H_ACTIVE   = 640,
  parameter int H_TOTAL    = 800,
  parameter int V_ACTIVE   = 480,
  parameter int V_TOTAL    = 525,
  parameter int CELL_SHIFT = 3,
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 8
) (
  input  logic              Master_Clock_In,
  input  logic              Reset_N_In,
  input  logic              Disp_Ena_In,
  input  logic [9:0]        Val_Col_In,
  input  logic [9:0]        Val_Row_In,
  input  logic              Wr_Req_In,
  input  logic [ADDR_W-1:0] Wr_Addr_In,
  input  logic [DATA_W-1:0] Wr_Data_In,
  output logic              Wr_Ack_Out,
  output logic [ADDR_W-1:0] Ram_Addr_Out,
  output logic [DATA_W-1:0] Ram_Data_Out,
  output logic              Ram_We_Out,
  input  logic [DATA_W-1:0] Ram_Data_In,
  output logic [DATA_W-1:0] Pixel_Data_Out,
  output logic              Pixel_Valid_Out
);

  localparam int COLS = H_ACTIVE >> CELL_SHIFT;
  localparam int ROWS = V_ACTIVE >> CELL_SHIFT;
  localparam logic [ADDR_W-1:0] COLS_A  = ADDR_W'(COLS);
  localparam logic [31:0]       N_CELLS = 32'(COLS * ROWS);

  typedef enum logic [1:0] {CMD_NONE, CMD_READ, CMD_WRITE} cmd_t;

  cmd_t              cmd_q, cmd_d;
  logic [10:0]       col_p3, row_p1, tc, tr;
  logic              col_wrap, scan_slot, wr_grant, wr_in_range;
  logic [ADDR_W-1:0] rd_addr, addr_d;
  logic [DATA_W-1:0] wdata_d;
  logic              we_d, ack_d;
  logic              rd_data_vld;
  logic [DATA_W-1:0] next_cell, pix_q;
  logic              disp_q;

  // Target pixel three clocks ahead, wrapping into the next line / frame.
  always_comb begin
    col_p3   = {1'b0, Val_Col_In} + 11'd3;
    row_p1   = {1'b0, Val_Row_In} + 11'd1;
    col_wrap = (col_p3 >= 11'(H_TOTAL));
    tc       = col_wrap ? (col_p3 - 11'(H_TOTAL)) : col_p3;
    if (!col_wrap)
      tr = {1'b0, Val_Row_In};
    else if (row_p1 == 11'(V_TOTAL))
      tr = '0;
    else
      tr = row_p1;
    scan_slot = (tc[CELL_SHIFT-1:0] == '0) && (tc < 11'(H_ACTIVE)) &&
                (tr < 11'(V_ACTIVE));
    rd_addr   = ADDR_W'(tr >> CELL_SHIFT) * COLS_A + ADDR_W'(tc >> CELL_SHIFT);
  end

`ifdef VGA_ARB_BLANK_WR_EN
  assign wr_grant = Wr_Req_In && !Disp_Ena_In;
`else
  assign wr_grant = Wr_Req_In;
`endif

  assign wr_in_range = (32'(Wr_Addr_In) < N_CELLS);

  // Per-cycle command decision: scan slot wins, otherwise a pending write.
  always_comb begin
    cmd_d   = CMD_NONE;
    addr_d  = Ram_Addr_Out;
    wdata_d = Ram_Data_Out;
    we_d    = 1'b0;
    ack_d   = 1'b0;
    if (scan_slot) begin
      cmd_d  = CMD_READ;
      addr_d = rd_addr;
    end else if (wr_grant) begin
      cmd_d   = CMD_WRITE;
      addr_d  = Wr_Addr_In;
      wdata_d = Wr_Data_In;
      we_d    = wr_in_range;   // out-of-range writes are acked but dropped
      ack_d   = 1'b1;
    end
  end

  // Command register and registered RAM interface.
  always_ff @(posedge Master_Clock_In or negedge Reset_N_In) begin
    if (!Reset_N_In) begin
      cmd_q        <= CMD_NONE;
      Ram_Addr_Out <= '0;
      Ram_Data_Out <= '0;
      Ram_We_Out   <= 1'b0;
      Wr_Ack_Out   <= 1'b0;
    end else begin
      cmd_q        <= cmd_d;
      Ram_Addr_Out <= addr_d;
      Ram_Data_Out <= wdata_d;
      Ram_We_Out   <= we_d;
      Wr_Ack_Out   <= ack_d;
    end
  end

  // Read pipeline: capture RAM data one cycle after a read address, then
  // present it at the first pixel of the cell.
  always_ff @(posedge Master_Clock_In or negedge Reset_N_In) begin
    if (!Reset_N_In) begin
      rd_data_vld <= 1'b0;
      next_cell   <= '0;
      pix_q       <= '0;
      disp_q      <= 1'b0;
    end else begin
      rd_data_vld <= (cmd_q == CMD_READ);
      if (rd_data_vld)
        next_cell <= Ram_Data_In;
      if (Val_Col_In[CELL_SHIFT-1:0] == '0)
        pix_q <= next_cell;
      disp_q <= Disp_Ena_In;
    end
  end

  assign Pixel_Valid_Out = disp_q;
  assign Pixel_Data_Out  = disp_q ? pix_q : '0;

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// Directed testbench for vga_vram_arbiter with a synchronous RAM model
// whose contents are mem[a] = a[7:0].
`timescale 1ns/1ps

module tb_vga_vram_arbiter;

  logic        clk;
  logic        rst_n;
  logic        disp;
  logic [9:0]  col, row;
  logic        wr_req;
  logic [12:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_ack;
  logic [12:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_we;
  logic [7:0]  ram_rdata;
  logic [7:0]  pix_data;
  logic        pix_valid;

  int n_checks = 0;
  int n_errors = 0;

  vga_vram_arbiter dut (
    .Master_Clock_In (clk),
    .Reset_N_In      (rst_n),
    .Disp_Ena_In     (disp),
    .Val_Col_In      (col),
    .Val_Row_In      (row),
    .Wr_Req_In       (wr_req),
    .Wr_Addr_In      (wr_addr),
    .Wr_Data_In      (wr_data),
    .Wr_Ack_Out      (wr_ack),
    .Ram_Addr_Out    (ram_addr),
    .Ram_Data_Out    (ram_wdata),
    .Ram_We_Out      (ram_we),
    .Ram_Data_In     (ram_rdata),
    .Pixel_Data_Out  (pix_data),
    .Pixel_Valid_Out (pix_valid)
  );

  initial begin
    clk = 1'b0;
    forever #20 clk = ~clk;
  end

  // synchronous RAM: data valid the cycle after the address
  always @(posedge clk) ram_rdata <= ram_addr[7:0];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; disp = 1'b1; row = 10'd0; col = 10'd795;
    wr_req = 1'b1; wr_addr = 13'd7; wr_data = 8'h33;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if ({wr_ack, ram_we, ram_addr, ram_wdata, pix_data, pix_valid} !== '0) begin
        n_errors++;
        $display("FAIL reset_outputs cyc %0d got ack=%0b we=%0b addr=%0d wd=%0h pix=%0h vld=%0b exp all 0",
                 i, wr_ack, ram_we, ram_addr, ram_wdata, pix_data, pix_valid);
      end
      col = col + 10'd1;
    end
    wr_req = 1'b0; disp = 1'b0; col = 10'd0; row = 10'd0;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_read_addr();
    int vc[7] = '{797, 5, 637, 5, 797, 797, 797};
    int vr[7] = '{0, 0, 0, 8, 7, 479, 524};
    int ea[7] = '{0, 1, 1, 81, 80, 80, 0};
    wr_req = 1'b0; disp = 1'b0;
    for (int i = 0; i < 7; i++) begin
      col = 10'(vc[i]); row = 10'(vr[i]);
      step();
      n_checks++;
      if (ram_addr !== 13'(ea[i]) || ram_we !== 1'b0) begin
        n_errors++;
        $display("FAIL read_addr col=%0d row=%0d got addr=%0d we=%0b exp addr=%0d we=0",
                 vc[i], vr[i], ram_addr, ram_we, ea[i]);
      end
    end
  endtask

  task automatic test_pixel_row();
    int c, r;
    logic       d;
    logic [7:0] exp_pix;
    wr_req = 1'b0;
    c = 790; r = 16;
    while (!(r == 17 && c > 660)) begin
      d = (c < 640) && (r < 480);
      col = 10'(c); row = 10'(r); disp = d;
      step();
      exp_pix = d ? 8'(((r >> 3) * 80) + (c >> 3)) : 8'h00;
      n_checks++;
      if (pix_valid !== d || pix_data !== exp_pix) begin
        n_errors++;
        $display("FAIL pixel col=%0d row=%0d got data=%0d vld=%0b exp data=%0d vld=%0b",
                 c, r, pix_data, pix_valid, exp_pix, d);
      end
      c++;
      if (c == 800) begin c = 0; r++; end
    end
    disp = 1'b0;
  endtask

  task automatic test_write_slot();
    disp = 1'b0; row = 10'd0; col = 10'd5;
    wr_req = 1'b1; wr_addr = 13'd100; wr_data = 8'hAB;
    step();
    n_checks++;
    if (wr_ack !== 1'b0 || ram_we !== 1'b0 || ram_addr !== 13'd1) begin
      n_errors++;
      $display("FAIL write_in_slot got ack=%0b we=%0b addr=%0d exp ack=0 we=0 addr=1",
               wr_ack, ram_we, ram_addr);
    end
    col = 10'd6;
    step();
    n_checks++;
    if (wr_ack !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 13'd100 || ram_wdata !== 8'hAB) begin
      n_errors++;
      $display("FAIL write_grant got ack=%0b we=%0b addr=%0d wd=%0h exp 1 1 100 ab",
               wr_ack, ram_we, ram_addr, ram_wdata);
    end
    wr_req = 1'b0; col = 10'd7;
    step();
    n_checks++;
    if (wr_ack !== 1'b0 || ram_we !== 1'b0 || ram_addr !== 13'd100) begin
      n_errors++;
      $display("FAIL write_release got ack=%0b we=%0b addr=%0d exp ack=0 we=0 addr=100",
               wr_ack, ram_we, ram_addr);
    end
  endtask

  task automatic test_back_to_back();
    int k = 0;
    int a;
    logic        slot;
    logic        e_we;
    logic [12:0] e_addr;
    disp = 1'b0; row = 10'd0; wr_req = 1'b1;
    for (int c = 0; c < 41; c++) begin
      a = (k < 4) ? 4797 + k : k;
      col = 10'(c); wr_addr = 13'(a); wr_data = 8'(a) ^ 8'h5A;
      step();
      slot = ((c % 8) == 5);
      e_we   = !slot && (a < 4800);
      e_addr = slot ? 13'((c + 3) >> 3) : 13'(a);
      n_checks++;
      if (wr_ack !== !slot || ram_we !== e_we || ram_addr !== e_addr ||
          (!slot && ram_wdata !== (8'(a) ^ 8'h5A))) begin
        n_errors++;
        $display("FAIL back_to_back col=%0d got ack=%0b we=%0b addr=%0d wd=%0h exp ack=%0b we=%0b addr=%0d",
                 c, wr_ack, ram_we, ram_addr, ram_wdata, !slot, e_we, e_addr);
      end
      if (!slot) k++;
    end
    wr_req = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    disp = 1'b0; row = 10'd0; col = 10'd0;
    wr_req = 1'b1; wr_addr = 13'd200; wr_data = 8'h11;
    step();
    n_checks++;
    if (wr_ack !== 1'b1 || ram_we !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_mid_pre got ack=%0b we=%0b exp 1 1", wr_ack, ram_we);
    end
    #5 rst_n = 1'b0;
    #1;
    n_checks++;
    if (wr_ack !== 1'b0 || ram_we !== 1'b0 || ram_addr !== 13'd0) begin
      n_errors++;
      $display("FAIL reset_mid_drop got ack=%0b we=%0b addr=%0d exp 0 0 0",
               wr_ack, ram_we, ram_addr);
    end
    wr_req = 1'b0;
    step();
    rst_n = 1'b1;
    col = 10'd1;
    step();
    n_checks++;
    if (wr_ack !== 1'b0 || ram_we !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_mid_after got ack=%0b we=%0b exp 0 0", wr_ack, ram_we);
    end
  endtask

  task automatic test_blank_wr();
    disp = 1'b1; row = 10'd0; col = 10'd0;
    wr_req = 1'b1; wr_addr = 13'd300; wr_data = 8'h42;
    step();
`ifdef VGA_ARB_BLANK_WR_EN
    n_checks++;
    if (wr_ack !== 1'b0 || ram_we !== 1'b0) begin
      n_errors++;
      $display("FAIL blank_wr_active got ack=%0b we=%0b exp 0 0", wr_ack, ram_we);
    end
    col = 10'd1;
    step();
    n_checks++;
    if (wr_ack !== 1'b0) begin
      n_errors++;
      $display("FAIL blank_wr_wait got ack=%0b exp 0", wr_ack);
    end
    disp = 1'b0; col = 10'd2;
    step();
`endif
    n_checks++;
    if (wr_ack !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 13'd300 || ram_wdata !== 8'h42) begin
      n_errors++;
      $display("FAIL blank_wr_grant got ack=%0b we=%0b addr=%0d wd=%0h exp 1 1 300 42",
               wr_ack, ram_we, ram_addr, ram_wdata);
    end
    wr_req = 1'b0; disp = 1'b0;
    step();
  endtask

  initial begin
    rst_n = 1'b0; disp = 1'b0; col = '0; row = '0;
    wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    test_reset();
    test_read_addr();
    test_pixel_row();
    test_write_slot();
    test_back_to_back();
    test_blank_wr();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
